// File: rtl/fifo_sample_buffer_if.sv
// rtl/fifo_sample_buffer_if.sv - write/read/status bundle for fifo_sample_buffer; FIFO_WATERMARK_EN adds watermark flags
interface fifo_sample_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  clr_i;
    logic                  wr_en_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  rd_en_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  rd_valid_o;
    logic                  full_o;
    logic                  empty_o;
    logic [ADDR_W:0]       count_o;
    logic                  ovf_o;
    logic                  udf_o;
`ifdef FIFO_WATERMARK_EN
    logic                  almost_full_o;
    logic                  almost_empty_o;

    modport master (
        output clr_i, wr_en_i, data_i, rd_en_i,
        input  data_o, rd_valid_o, full_o, empty_o, count_o, ovf_o, udf_o,
        input  almost_full_o, almost_empty_o
    );
    modport slave (
        input  clr_i, wr_en_i, data_i, rd_en_i,
        output data_o, rd_valid_o, full_o, empty_o, count_o, ovf_o, udf_o,
        output almost_full_o, almost_empty_o
    );
`else
    modport master (
        output clr_i, wr_en_i, data_i, rd_en_i,
        input  data_o, rd_valid_o, full_o, empty_o, count_o, ovf_o, udf_o
    );
    modport slave (
        input  clr_i, wr_en_i, data_i, rd_en_i,
        output data_o, rd_valid_o, full_o, empty_o, count_o, ovf_o, udf_o
    );
`endif
endinterface

// File: rtl/fifo_sample_buffer.sv
// rtl/fifo_sample_buffer.sv - synchronous sample FIFO with sticky over/underflow flags; FIFO_WATERMARK_EN adds almost_full/almost_empty
module fifo_sample_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
`ifdef FIFO_WATERMARK_EN
    ,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
`endif
) (
    input logic                 clk,
    input logic                 rst,
    fifo_sample_buffer_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    if ($bits(bus.data_i) != DATA_WIDTH) begin : g_width_check
        $error("fifo_sample_buffer: interface data width differs from DATA_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W:0]       count;
    logic [ADDR_W:0]       count_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  rd_valid_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Flush wins over both requests; a full FIFO still accepts a write when a read frees a slot.
    always_comb begin
        rd_acc    = !bus.clr_i && bus.rd_en_i && !empty;
        wr_acc    = rst && !bus.clr_i && bus.wr_en_i && (!full || rd_acc);
        count_nxt = count;
        if (bus.clr_i)
            count_nxt = '0;
        else if (wr_acc && !rd_acc)
            count_nxt = count + 1'b1;
        else if (rd_acc && !wr_acc)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= bus.data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            count      <= count_nxt;
            rd_valid_q <= rd_acc;
            if (bus.clr_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf_q  <= 1'b0;
                udf_q  <= 1'b0;
            end else begin
                if (wr_acc)
                    wr_ptr <= wr_ptr + 1'b1;
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    data_q <= mem[rd_ptr];
                end
                if (bus.wr_en_i && full && !rd_acc)
                    ovf_q <= 1'b1;
                if (bus.rd_en_i && empty)
                    udf_q <= 1'b1;
            end
        end
    end

    assign bus.data_o     = data_q;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.full_o     = full;
    assign bus.empty_o    = empty;
    assign bus.count_o    = count;
    assign bus.ovf_o      = ovf_q;
    assign bus.udf_o      = udf_q;

`ifdef FIFO_WATERMARK_EN
    localparam logic [ADDR_W:0] AF_CNT = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT = (ADDR_W + 1)'(AE_LEVEL);

    logic almost_full_q;
    logic almost_empty_q;

    // Decoded from the next count so the flags change on the same edge as count_o.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= (count_nxt >= AF_CNT);
            almost_empty_q <= (count_nxt <= AE_CNT);
        end
    end

    assign bus.almost_full_o  = almost_full_q;
    assign bus.almost_empty_o = almost_empty_q;
`endif
endmodule

// File: tb/tb_fifo_sample_buffer.sv
// tb/tb_fifo_sample_buffer.sv - self-checking bench for fifo_sample_buffer (table vectors plus queue scoreboard)
module tb_fifo_sample_buffer;
    localparam int DW  = 16;
    localparam int DEP = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_sample_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEP)) bus ();

    fifo_sample_buffer #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          rd;
        bit          clr;
        logic [15:0] data;
        int          exp_count;
        bit          exp_ovf;
        bit          exp_udf;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [15:0] model[$];
    logic [15:0] sb[$];
    logic [15:0] m_data  = '0;
    bit          m_ovf   = 1'b0;
    bit          m_udf   = 1'b0;
    bit          m_valid = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, bus.count_o, 0);
        chk({tag, "_empty"}, bus.empty_o, 1);
        chk({tag, "_full"}, bus.full_o, 0);
        chk({tag, "_data"}, bus.data_o, 0);
        chk({tag, "_valid"}, bus.rd_valid_o, 0);
        chk({tag, "_ovf"}, bus.ovf_o, 0);
        chk({tag, "_udf"}, bus.udf_o, 0);
`ifdef FIFO_WATERMARK_EN
        chk({tag, "_afull"}, bus.almost_full_o, 0);
        chk({tag, "_aempty"}, bus.almost_empty_o, 1);
`endif
    endtask

    // Called at posedge+1: drive one cycle, advance the model, then check at the next posedge+1.
    task automatic step(input bit w, input bit r, input bit c, input logic [15:0] d);
        bit racc;
        bit wacc;
        bus.wr_en_i = w;
        bus.rd_en_i = r;
        bus.clr_i   = c;
        bus.data_i  = d;
        if (c) begin
            model.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_valid = 1'b0;
        end else begin
            racc = r && (model.size() > 0);
            wacc = w && (model.size() < DEP || racc);
            if (r && model.size() == 0) m_udf = 1'b1;
            if (w && model.size() == DEP && !racc) m_ovf = 1'b1;
            if (racc) sb.push_back(model.pop_front());
            if (wacc) model.push_back(d);
            m_valid = racc;
        end
        @(posedge clk);
        #1;
        bus.wr_en_i = 1'b0;
        bus.rd_en_i = 1'b0;
        bus.clr_i   = 1'b0;
        if (m_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: read expected but queue empty");
            end else begin
                m_data = sb.pop_front();
            end
        end
        chk("rd_valid", bus.rd_valid_o, m_valid);
        chk("data_o", bus.data_o, m_data);
        chk("count_o", bus.count_o, model.size());
        chk("full_o", bus.full_o, model.size() == DEP);
        chk("empty_o", bus.empty_o, model.size() == 0);
        chk("ovf_o", bus.ovf_o, m_ovf);
        chk("udf_o", bus.udf_o, m_udf);
`ifdef FIFO_WATERMARK_EN
        chk("almost_full", bus.almost_full_o, model.size() >= DEP - 2);
        chk("almost_empty", bus.almost_empty_o, model.size() <= 2);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[19];
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, 1'b0, 1'b0, 16'(i + 1), i + 1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 16'h7FFF, 8, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 16'h8000, 8, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++)
            vecs[10 + i] = '{1'b0, 1'b1, 1'b0, 16'h0000, 7 - i, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b1};

        bus.wr_en_i = 1'b0;
        bus.rd_en_i = 1'b0;
        bus.clr_i   = 1'b0;
        bus.data_i  = '0;

        // Reset held with random traffic.
        for (int i = 0; i < 4; i++) begin
            bus.wr_en_i = 1'($urandom_range(0, 1));
            bus.rd_en_i = 1'($urandom_range(0, 1));
            bus.data_i  = 16'($urandom);
            @(posedge clk);
            #1;
            chk_reset_state("rst_hold");
        end
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 16'h0);

        // Fill, overflow, full wr+rd, drain, underflow.
        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].data);
            chk($sformatf("vec%0d_count", i), bus.count_o, vecs[i].exp_count);
            chk($sformatf("vec%0d_ovf", i), bus.ovf_o, vecs[i].exp_ovf);
            chk($sformatf("vec%0d_udf", i), bus.udf_o, vecs[i].exp_udf);
        end
        chk("last_read_8000", bus.data_o, 16'h8000);

        // Underflow with simultaneous write, then interleaved traffic across pointer wrap.
        step(1'b0, 1'b0, 1'b1, 16'h0);
        step(1'b1, 1'b1, 1'b0, 16'hFFFF);
        chk("udf_same_cycle", bus.udf_o, 1);
        chk("udf_no_valid", bus.rd_valid_o, 0);
        chk("udf_count1", bus.count_o, 1);
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 16'($urandom));
            chk("count_le_depth", bus.count_o <= DEP, 1);
        end

        // Flush at count 5 with a write in the same cycle.
        while (model.size() > 0) step(1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'(16'h0100 + i));
        chk("pre_flush_count", bus.count_o, 5);
        step(1'b1, 1'b1, 1'b1, 16'hBEEF);
        chk("flush_count", bus.count_o, 0);
        chk("flush_empty", bus.empty_o, 1);

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'(16'h0A00 + i));
        step(1'b0, 1'b1, 1'b0, 16'h0);
        bus.wr_en_i = 1'b1;
        bus.data_i  = 16'h5555;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_state("rst_async");
        @(posedge clk);
        #1;
        bus.wr_en_i = 1'b0;
        rst = 1'b1;
        model.delete();
        sb.delete();
        m_data = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        step(1'b0, 1'b0, 1'b0, 16'h0);

`ifdef FIFO_WATERMARK_EN
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 16'(16'h0C00 + i));
        chk("wm_afull_at6", bus.almost_full_o, 1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
        chk("wm_aempty_at2", bus.almost_empty_o, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
